strtup_seq: RTL and testbench

- Parametrised startup/shutdown sequencer, clocked by the user startup clock UCLK.
- Successor to the bare startup primitive: on a request it releases NUM_PHASES enables one at a time, PHASE_DLY cycles apart.
- On de-request it drops the enables in reverse order.
- Sits between the device startup clock and user-logic enables (e.g. I/O enable, core reset release, PLL-dependent domains).

---
 rtl/strtup_pkg.sv | 50 +++++
 rtl/strtup_dly_cnt.sv | 48 ++++
 rtl/strtup_seq.sv | 180 ++++++++++++++++++
 tb/tb_strtup_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/strtup_pkg.sv
// Shared types, default constants and mask helpers for the startup sequencer.
//   state_e           sequencer states OFF/UP/ON/DOWN
//   DEF_*             default parameter values
//   lowest_clr_mask   one-hot mask of the lowest clear bit (priority encoder)
//   highest_set_mask  one-hot mask of the highest set bit (priority encoder)
package strtup_pkg;

   localparam int unsigned MAX_PHASES     = 16;
   localparam int unsigned DEF_NUM_PHASES = 4;
   localparam int unsigned DEF_PHASE_DLY  = 16;
   localparam int unsigned DEF_TIMEOUT    = 1024;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_UP   = 2'd1,
      ST_ON   = 2'd2,
      ST_DOWN = 2'd3
   } state_e;

   // Next bit to raise: lowest clear bit scanning upward.
   function automatic logic [MAX_PHASES-1:0] lowest_clr_mask(input logic [MAX_PHASES-1:0] v);
      logic [MAX_PHASES-1:0] m;
      logic                  found;
      m     = '0;
      found = 1'b0;
      for (int i = 0; i < int'(MAX_PHASES); i++) begin
         if (!found && !v[i]) begin
            m[i]  = 1'b1;
            found = 1'b1;
         end
      end
      return m;
   endfunction

   // Next bit to drop: highest set bit scanning downward.
   function automatic logic [MAX_PHASES-1:0] highest_set_mask(input logic [MAX_PHASES-1:0] v);
      logic [MAX_PHASES-1:0] m;
      logic                  found;
      m     = '0;
      found = 1'b0;
      for (int i = int'(MAX_PHASES) - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            m[i]  = 1'b1;
            found = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/strtup_dly_cnt.sv
// Phase-delay counter for the startup sequencer.
//   clk   startup clock
//   rst   synchronous active-high reset
//   clr   force counter to 0 (state entry, idle states)
//   hold  freeze counter
//   tc_c  combinational terminal-count flag: counter at PHASE_DLY-1 and not held
module strtup_dly_cnt
   import strtup_pkg::*;
#(
   parameter int unsigned PHASE_DLY = DEF_PHASE_DLY
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic hold,
   output logic tc_c
);

   localparam int unsigned CNT_W = $clog2(PHASE_DLY + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // With PHASE_DLY=1 the terminal value is 0, so the counter never leaves 0.
   assign tc_c = !hold && (cnt_q == CNT_W'(PHASE_DLY - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (hold) begin
         cnt_d = cnt_q;
      end else if (tc_c) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/strtup_seq.sv
// Startup/shutdown sequencer: raises NUM_PHASES thermometer enables one at a
// time, PHASE_DLY cycles apart, on REQ=1 and drops them in reverse on REQ=0.
//   UCLK      startup clock, rising edge
//   RST       synchronous active-high reset
//   REQ       level request (1 = up, 0 = down)
//   HOLD      freezes the phase-delay counter in UP/DOWN
//   PHASE_EN  thermometer enables, bit 0 first up / last down
//   BUSY      1 in UP or DOWN
//   DONE      1 in ON
//   ERR       sticky hold-timeout fault
// Optional macro STRTUP_TIMEOUT_EN: hold-timeout watchdog (TIMEOUT consecutive
// held cycles in UP/DOWN force an orderly shutdown and latch ERR until RST).
module strtup_seq
   import strtup_pkg::*;
#(
   parameter int unsigned NUM_PHASES = DEF_NUM_PHASES,
   parameter int unsigned PHASE_DLY  = DEF_PHASE_DLY,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  UCLK,
   input  logic                  RST,
   input  logic                  REQ,
   input  logic                  HOLD,
   output logic [NUM_PHASES-1:0] PHASE_EN,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR
);

   // Elaboration-time legality check on parameters.
   if (NUM_PHASES == 0 || NUM_PHASES > MAX_PHASES ||
       PHASE_DLY == 0 || PHASE_DLY > 65535 || TIMEOUT == 0) begin : g_param_chk
      $error("strtup_seq: illegal parameter value");
   end

   state_e                state_q;
   state_e                state_d;
   logic [NUM_PHASES-1:0] phase_en_q;
   logic [NUM_PHASES-1:0] phase_en_d;
   logic                  busy_q;
   logic                  busy_d;
   logic                  done_q;
   logic                  done_d;

   logic [NUM_PHASES-1:0] up_nxt_c;
   logic [NUM_PHASES-1:0] dn_nxt_c;
   logic                  step_c;
   logic                  clr_c;
   logic                  tc_c;
   logic                  req_c;
   logic                  hold_c;
   logic                  to_hit_c;
   logic                  err_q;

   // Candidate enable vectors for a step up / step down.
   assign up_nxt_c = phase_en_q
                   | NUM_PHASES'(lowest_clr_mask(MAX_PHASES'(phase_en_q)));
   assign dn_nxt_c = phase_en_q
                   & ~NUM_PHASES'(highest_set_mask(MAX_PHASES'(phase_en_q)));

`ifdef STRTUP_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] hold_cnt_q;
   logic [TO_W-1:0] hold_cnt_d;
   logic            err_d;
   logic            act_c;

   // Once faulted, REQ and HOLD are masked so DOWN runs to OFF and stays there.
   assign req_c  = REQ & ~err_q;
   assign hold_c = HOLD & ~err_q;
   assign act_c  = (state_q == ST_UP) || (state_q == ST_DOWN);

   assign to_hit_c = act_c && HOLD && !err_q && (hold_cnt_q == TO_W'(TIMEOUT - 1));
   assign err_d    = err_q | to_hit_c;

   // Consecutive-hold counter; restarts on HOLD=0 or any state change.
   always_comb begin
      hold_cnt_d = '0;
      if (act_c && HOLD && !err_q && !to_hit_c && (state_d == state_q)) begin
         hold_cnt_d = hold_cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge UCLK) begin
      if (RST) begin
         hold_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         err_q      <= err_d;
      end
   end
`else
   assign req_c    = REQ;
   assign hold_c   = HOLD;
   assign to_hit_c = 1'b0;
   assign err_q    = 1'b0;
`endif

   strtup_dly_cnt #(
      .PHASE_DLY (PHASE_DLY)
   ) u_dly_cnt (
      .clk  (UCLK),
      .rst  (RST),
      .clr  (clr_c),
      .hold (hold_c),
      .tc_c (tc_c)
   );

   // State and registered outputs.
   always_ff @(posedge UCLK) begin
      if (RST) begin
         state_q    <= ST_OFF;
         phase_en_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_en_q <= phase_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next state; a REQ reversal takes priority over a pending phase step.
   always_comb begin
      state_d = state_q;
      step_c  = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (req_c) state_d = ST_UP;
         end
         ST_UP: begin
            if (!req_c) begin
               state_d = ST_DOWN;
            end else if (tc_c) begin
               step_c = 1'b1;
               if (&up_nxt_c) state_d = ST_ON;
            end
         end
         ST_ON: begin
            if (!req_c) state_d = ST_DOWN;
         end
         ST_DOWN: begin
            if (req_c) begin
               state_d = ST_UP;
            end else if (tc_c) begin
               step_c = 1'b1;
               if (dn_nxt_c == '0) state_d = ST_OFF;
            end
         end
         default: state_d = ST_OFF;
      endcase
      if (to_hit_c) begin
         state_d = ST_DOWN;
         step_c  = 1'b0;
      end
   end

   // Counter restarts on every state change and idles at 0 in OFF/ON.
   assign clr_c = (state_q == ST_OFF) || (state_q == ST_ON) ||
                  (state_d != state_q) || to_hit_c;

   // Output next values.
   always_comb begin
      phase_en_d = phase_en_q;
      if (step_c) begin
         phase_en_d = (state_q == ST_UP) ? up_nxt_c : dn_nxt_c;
      end
      busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
      done_d = (state_d == ST_ON);
   end

   assign PHASE_EN = phase_en_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_strtup_seq.sv
// Directed bench for strtup_seq: main instance NUM_PHASES=4 PHASE_DLY=3 TIMEOUT=8,
// plus a PHASE_DLY=1 instance for the one-step-per-cycle corner.
module tb_strtup_seq;

   localparam int unsigned NP = 4;
   localparam int unsigned PD = 3;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          hold;
   logic [NP-1:0] phase_en;
   logic          busy;
   logic          done;
   logic          err;

   logic          req1;
   logic [1:0]    phase_en1;
   logic          busy1;
   logic          done1;
   logic          err1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   strtup_seq #(
      .NUM_PHASES (NP),
      .PHASE_DLY  (PD),
      .TIMEOUT    (TO)
   ) u_dut (
      .UCLK     (clk),
      .RST      (rst),
      .REQ      (req),
      .HOLD     (hold),
      .PHASE_EN (phase_en),
      .BUSY     (busy),
      .DONE     (done),
      .ERR      (err)
   );

   strtup_seq #(
      .NUM_PHASES (2),
      .PHASE_DLY  (1),
      .TIMEOUT    (TO)
   ) u_dut_fast (
      .UCLK     (clk),
      .RST      (rst),
      .REQ      (req1),
      .HOLD     (hold),
      .PHASE_EN (phase_en1),
      .BUSY     (busy1),
      .DONE     (done1),
      .ERR      (err1)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NP-1:0] therm(input int k);
      return NP'((32'd1 << k) - 32'd1);
   endfunction

   // One rising edge, then sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int k, input logic b, input logic d);
      check_eq({tag, "_en"},   32'(phase_en), 32'(therm(k)));
      check_eq({tag, "_busy"}, 32'(busy),     32'(b));
      check_eq({tag, "_done"}, 32'(done),     32'(d));
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = 1'b0;
      hold = 1'b0;
      req1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk_out("rst", 0, 1'b0, 1'b0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_fast_en", 32'(phase_en1), 32'd0);
   endtask

   initial begin
      int k;

      // Full up then down; HOLD toggled while ON must be ignored.
      do_reset();
      req = 1'b1;
      tick();
      chk_out("up@0", 0, 1'b1, 1'b0);
      for (int e = 1; e <= 12; e++) begin
         tick();
         chk_out($sformatf("up@%0d", e), e / 3, e < 12, e >= 12);
      end
      for (int e = 13; e <= 19; e++) begin
         hold = (e % 2 == 1);
         tick();
      end
      hold = 1'b0;
      chk_out("on@19", 4, 1'b0, 1'b1);
      req = 1'b0;
      tick();
      chk_out("dn@20", 4, 1'b1, 1'b0);
      for (int e = 21; e <= 32; e++) begin
         tick();
         chk_out($sformatf("dn@%0d", e), 4 - (e - 20) / 3, e < 32, 1'b0);
      end
      check_eq("err_idle", 32'(err), 32'd0);

      // HOLD for edges 4..8 delays every later step by 5.
      do_reset();
      req = 1'b1;
      tick();
      for (int e = 1; e <= 17; e++) begin
         hold = (e >= 4 && e <= 8);
         tick();
         k = (e <= 8) ? ((e >= 3) ? 1 : 0) : (e - 5) / 3;
         chk_out($sformatf("hold@%0d", e), k, e < 17, e >= 17);
      end
      hold = 1'b0;

      // Reversal in UP at PHASE_EN=0011: REQ low sampled at edge 8.
      do_reset();
      req = 1'b1;
      tick();
      for (int e = 1; e <= 7; e++) tick();
      chk_out("rev@7", 2, 1'b1, 1'b0);
      req = 1'b0;
      tick();
      chk_out("rev@8", 2, 1'b1, 1'b0);
      for (int e = 9; e <= 14; e++) begin
         tick();
         k = (e < 11) ? 2 : ((e < 14) ? 1 : 0);
         chk_out($sformatf("rev@%0d", e), k, e < 14, 1'b0);
      end

      // Reset mid-UP with REQ held, then restart.
      do_reset();
      req = 1'b1;
      tick();
      for (int e = 1; e <= 7; e++) tick();
      chk_out("mid@7", 2, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk_out("mid_rst@8", 0, 1'b0, 1'b0);
      check_eq("mid_rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick();
      chk_out("restart@9", 0, 1'b1, 1'b0);
      tick();
      tick();
      chk_out("restart@11", 0, 1'b1, 1'b0);
      tick();
      chk_out("restart@12", 1, 1'b1, 1'b0);

      // REQ toggling every cycle never moves PHASE_EN; an empty DOWN ends in OFF.
      do_reset();
      for (int e = 0; e <= 11; e++) begin
         req = (e % 2 == 0);
         tick();
         chk_out($sformatf("tog@%0d", e), 0, 1'b1, 1'b0);
      end
      req = 1'b0;
      tick();
      tick();
      chk_out("tog@13", 0, 1'b1, 1'b0);
      tick();
      chk_out("tog@14", 0, 1'b0, 1'b0);

      // PHASE_DLY=1: one phase change per cycle.
      do_reset();
      req1 = 1'b1;
      tick();
      check_eq("fast@0_en", 32'(phase_en1), 32'd0);
      check_eq("fast@0_busy", 32'(busy1), 32'd1);
      tick();
      check_eq("fast@1_en", 32'(phase_en1), 32'd1);
      tick();
      check_eq("fast@2_en", 32'(phase_en1), 32'd3);
      check_eq("fast@2_done", 32'(done1), 32'd1);
      check_eq("fast@2_busy", 32'(busy1), 32'd0);
      req1 = 1'b0;
      tick();
      check_eq("fast@3_en", 32'(phase_en1), 32'd3);
      check_eq("fast@3_busy", 32'(busy1), 32'd1);
      tick();
      check_eq("fast@4_en", 32'(phase_en1), 32'd1);
      tick();
      check_eq("fast@5_en", 32'(phase_en1), 32'd0);
      check_eq("fast@5_busy", 32'(busy1), 32'd0);
      check_eq("fast_err", 32'(err1), 32'd0);

`ifdef STRTUP_TIMEOUT_EN
      // HOLD from PHASE_EN=0011: fault after 8 held edges, forced shutdown.
      do_reset();
      req = 1'b1;
      tick();
      for (int e = 1; e <= 6; e++) tick();
      chk_out("to@6", 2, 1'b1, 1'b0);
      hold = 1'b1;
      for (int e = 7; e <= 13; e++) tick();
      chk_out("to@13", 2, 1'b1, 1'b0);
      check_eq("to@13_err", 32'(err), 32'd0);
      tick();
      chk_out("to@14", 2, 1'b1, 1'b0);
      check_eq("to@14_err", 32'(err), 32'd1);
      for (int e = 15; e <= 20; e++) begin
         tick();
         k = (e < 17) ? 2 : ((e < 20) ? 1 : 0);
         chk_out($sformatf("to@%0d", e), k, e < 20, 1'b0);
      end
      for (int e = 21; e <= 25; e++) tick();
      chk_out("to_off", 0, 1'b0, 1'b0);
      check_eq("to_off_err", 32'(err), 32'd1);
      hold = 1'b0;
      do_reset();
`else
      // Long HOLD only freezes the sequence; no fault without the watchdog.
      do_reset();
      req = 1'b1;
      tick();
      for (int e = 1; e <= 6; e++) tick();
      hold = 1'b1;
      for (int e = 7; e <= 30; e++) tick();
      chk_out("hold_long", 2, 1'b1, 1'b0);
      check_eq("hold_long_err", 32'(err), 32'd0);
      hold = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
